// File: rtl/bcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : bcd_pkg                                                    |
// | Purpose  : Shared BCD types, constants and helpers for the           |
// |            digit-serial BCD adder.                                    |
// | Contents : bcd_digit_t, BCD_MAX, BCD_CORR, ctrl_state_t, is_bcd()    |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX  = 4'd9;
   localparam bcd_digit_t BCD_CORR = 4'd6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } ctrl_state_t;

   function automatic logic is_bcd(input bcd_digit_t d);
      return (d <= BCD_MAX);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_add.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bcd_digit_add                                              |
// | Purpose  : Combinational single-digit BCD adder with carry.          |
// | Ports    : a, b     - BCD digits (assumed 0..9)                       |
// |            cin      - carry in                                        |
// |            digit    - BCD sum digit                                   |
// |            cout     - decimal carry out                               |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module bcd_digit_add
   import bcd_pkg::*;
(
   input  bcd_digit_t a,
   input  bcd_digit_t b,
   input  logic       cin,
   output bcd_digit_t digit,
   output logic       cout
);

   // Five bits hold the worst case 9 + 9 + 1 = 19.
   logic [4:0] raw;

   always_comb begin
      raw   = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
      digit = raw[3:0];
      cout  = 1'b0;
      if (raw > {1'b0, BCD_MAX}) begin
         // Adding 6 in four bits skips the six unused codes A..F.
         digit = raw[3:0] + BCD_CORR;
         cout  = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/bcd_serial_add_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bcd_serial_add_ctrl                                        |
// | Purpose  : Digit-serial N-digit BCD adder. One shared digit adder is  |
// |            stepped across the operands, least-significant first.     |
// | Ports    : clk, reset (async, active high)                            |
// |            in_valid/in_ready   - operand handshake (a, b, ci)         |
// |            out_valid/out_ready - result handshake (sum, co, err)      |
// |            busy                - high while adding or holding result  |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module bcd_serial_add_ctrl
   import bcd_pkg::*;
#(
   parameter int N_DIGITS = 4
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*N_DIGITS-1:0] a,
   input  logic [4*N_DIGITS-1:0] b,
   input  logic                  ci,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*N_DIGITS-1:0] sum,
   output logic                  co,
   output logic                  err,
   output logic                  busy
);

   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

   ctrl_state_t           state;
   ctrl_state_t           state_next;
   logic [IDX_W-1:0]      idx;
   logic                  carry;
   logic                  started;
   logic [4*N_DIGITS-1:0] a_reg;
   logic [4*N_DIGITS-1:0] b_reg;
   logic [4*N_DIGITS-1:0] sum_reg;
   logic                  co_reg;
   logic                  err_reg;

   bcd_digit_t            a_dig;
   bcd_digit_t            b_dig;
   bcd_digit_t            dig_sum;
   logic                  dig_carry;
   logic                  ops_ok;
   logic                  accept;
   logic                  last_digit;

   // in_ready stays low until the first edge after reset is released.
   assign in_ready   = started && (state == IDLE);
   assign accept     = in_ready && in_valid;
   assign out_valid  = (state == DONE);
   assign busy       = (state != IDLE);
   assign sum        = sum_reg;
   assign co         = co_reg;
   assign err        = err_reg;
   assign last_digit = (idx == LAST_IDX);

   // Operand digit mux feeding the shared adder.
   always_comb begin
      a_dig = '0;
      b_dig = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            a_dig = a_reg[4*i +: 4];
            b_dig = b_reg[4*i +: 4];
         end
      end
   end

   // Screen the incoming operands for non-decimal digits.
   always_comb begin
      ops_ok = 1'b1;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (!is_bcd(a[4*i +: 4]) || !is_bcd(b[4*i +: 4])) begin
            ops_ok = 1'b0;
         end
      end
   end

   bcd_digit_add u_digit_add (
      .a     (a_dig),
      .b     (b_dig),
      .cin   (carry),
      .digit (dig_sum),
      .cout  (dig_carry)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = ops_ok ? ADD : DONE;
            end
         end
         ADD: begin
            if (last_digit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         started <= 1'b0;
         idx     <= '0;
         carry   <= 1'b0;
         a_reg   <= '0;
         b_reg   <= '0;
         sum_reg <= '0;
         co_reg  <= 1'b0;
         err_reg <= 1'b0;
      end else begin
         started <= 1'b1;
         if (state == IDLE && accept) begin
            a_reg   <= a;
            b_reg   <= b;
            sum_reg <= '0;
            idx     <= '0;
            carry   <= ci;
            co_reg  <= 1'b0;
            err_reg <= !ops_ok;
         end else if (state == ADD) begin
            for (int i = 0; i < N_DIGITS; i++) begin
               if (idx == IDX_W'(i)) begin
                  sum_reg[4*i +: 4] <= dig_sum;
               end
            end
            carry <= dig_carry;
            idx   <= idx + IDX_W'(1);
            if (last_digit) begin
               co_reg <= dig_carry;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_add_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_bcd_serial_add_ctrl                                     |
// | Purpose  : Self-checking bench for bcd_serial_add_ctrl (N_DIGITS=4). |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_bcd_serial_add_ctrl;

   localparam int N = 4;
   localparam int W = 4 * N;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         ci = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         co;
   logic         err;
   logic         busy;

   int checks   = 0;
   int failures = 0;

   bcd_serial_add_ctrl #(.N_DIGITS(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .ci        (ci),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .co        (co),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         ci;
      int           hold;
      logic [W-1:0] s;
      logic         co;
      logic         err;
   } vec_t;

   vec_t vt [9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Decimal reference: digits to integers, add, convert back.
   function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mci,
                                 output logic [W-1:0] ms, output logic mco, output logic merr);
      longint va = 0, vb = 0, p = 1, t;
      merr = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (ma[4*i +: 4] > 4'd9 || mb[4*i +: 4] > 4'd9) merr = 1'b1;
         va += longint'(ma[4*i +: 4]) * p;
         vb += longint'(mb[4*i +: 4]) * p;
         p  *= 10;
      end
      ms  = '0;
      mco = 1'b0;
      if (!merr) begin
         t   = va + vb + longint'(mci);
         mco = (t >= p);
         t   = t % p;
         for (int i = 0; i < N; i++) begin
            ms[4*i +: 4] = 4'(t % 10);
            t = t / 10;
         end
      end
   endfunction

   // One full transaction. Entered and left at #1 after a rising edge.
   // lat counts rising edges after the accepting edge until out_valid.
   task automatic txn(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tci, input int hold,
                      output logic [W-1:0] rs, output logic rco, output logic rerr, output int lat);
      int guard = 0;
      rs = '0; rco = 1'b0; rerr = 1'b0; lat = -1;
      while (!in_ready && guard < 40) begin
         @(posedge clk); #1; guard++;
      end
      if (!in_ready) begin
         chk("in_ready_wait_timeout", 64'(in_ready), 64'd1);
         return;
      end
      a = ta; b = tb_; ci = tci; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      if (!out_valid) begin
         chk("out_valid_wait_timeout", 64'(out_valid), 64'd1);
         return;
      end
      rs = sum; rco = co; rerr = err;
      chk("done_busy_inready", {62'd0, busy, in_ready}, 64'b10);
      for (int h = 0; h < hold; h++) begin
         in_valid = h[0];
         a = W'($urandom); b = W'($urandom);
         @(posedge clk); #1;
         chk("hold_stable", {out_valid, in_ready, co, err, sum}, {1'b1, 1'b0, rco, rerr, rs});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("handoff_idle", {61'd0, out_valid, in_ready, busy}, 64'b010);
      chk("handoff_result_kept", {co, err, sum}, {rco, rerr, rs});
   endtask

   logic [W-1:0] rs, es;
   logic         rco, rerr, eco, eerr;
   int           lat;
   int           acc [3];
   logic [W-1:0] bb_a [3], bb_b [3], bb_s [3];
   logic         bb_ci [3];
   int           k, nres;
   bit           will_accept;

   initial begin
      vt[0] = '{16'h1234, 16'h5678, 1'b0, 0, 16'h6912, 1'b0, 1'b0};
      vt[1] = '{16'h9999, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0};
      vt[2] = '{16'h0999, 16'h0000, 1'b1, 0, 16'h1000, 1'b0, 1'b0};
      vt[3] = '{16'h12A4, 16'h0000, 1'b0, 0, 16'h0000, 1'b0, 1'b1};
      vt[4] = '{16'h1234, 16'h000F, 1'b0, 0, 16'h0000, 1'b0, 1'b1};
      vt[5] = '{16'h4567, 16'h5555, 1'b0, 6, 16'h0122, 1'b1, 1'b0};
      vt[6] = '{16'h9999, 16'h9999, 1'b1, 1, 16'h9999, 1'b1, 1'b0};
      vt[7] = '{16'h0000, 16'h0000, 1'b0, 0, 16'h0000, 1'b0, 1'b0};
      vt[8] = '{16'h0005, 16'h0004, 1'b0, 2, 16'h0009, 1'b0, 1'b0};

      // Reset state.
      #2;
      chk("reset_outputs", {59'd0, out_valid, busy, co, err, in_ready}, 64'd0);
      chk("reset_sum", 64'(sum), 64'd0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("in_ready_before_first_edge", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      chk("in_ready_after_first_edge", 64'(in_ready), 64'd1);

      // Directed vector table.
      foreach (vt[i]) begin
         txn(vt[i].a, vt[i].b, vt[i].ci, vt[i].hold, rs, rco, rerr, lat);
         chk($sformatf("vec%0d_sum", i), 64'(rs), 64'(vt[i].s));
         chk($sformatf("vec%0d_co", i), 64'(rco), 64'(vt[i].co));
         chk($sformatf("vec%0d_err", i), 64'(rerr), 64'(vt[i].err));
         chk($sformatf("vec%0d_latency", i), 64'(lat), vt[i].err ? 64'd0 : 64'(N));
      end

      // Reset two cycles into ADD discards the result at once.
      while (!in_ready) begin @(posedge clk); #1; end
      a = 16'h9999; b = 16'h9999; ci = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk("mid_add_busy", 64'(busy), 64'd1);
      reset = 1'b1;
      #1;
      chk("async_reset_flags", {60'd0, out_valid, co, busy, in_ready}, 64'd0);
      chk("async_reset_sum", 64'(sum), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      txn(16'h0005, 16'h0004, 1'b0, 0, rs, rco, rerr, lat);
      chk("post_reset_sum", {rco, rerr, rs}, {1'b0, 1'b0, 16'h0009});

      // Back-to-back with in_valid held high.
      bb_a[0] = 16'h1234; bb_b[0] = 16'h5678; bb_ci[0] = 1'b0;
      bb_a[1] = 16'h0999; bb_b[1] = 16'h0000; bb_ci[1] = 1'b1;
      bb_a[2] = 16'h4567; bb_b[2] = 16'h5555; bb_ci[2] = 1'b0;
      k = 0; nres = 0;
      out_ready = 1'b1;
      a = bb_a[0]; b = bb_b[0]; ci = bb_ci[0]; in_valid = 1'b1;
      for (int cyc = 0; cyc < 100 && nres < 3; cyc++) begin
         will_accept = in_valid && in_ready;
         @(posedge clk); #1;
         if (will_accept) begin
            acc[k] = cyc;
            k++;
            if (k < 3) begin
               a = bb_a[k]; b = bb_b[k]; ci = bb_ci[k];
            end else begin
               in_valid = 1'b0;
            end
         end
         if (out_valid && nres < 3) begin
            bb_s[nres] = sum;
            nres++;
         end
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("b2b_accepts", 64'(k), 64'd3);
      chk("b2b_results", 64'(nres), 64'd3);
      if (k == 3) begin
         chk("b2b_spacing01", 64'(acc[1] - acc[0]), 64'(N + 2));
         chk("b2b_spacing12", 64'(acc[2] - acc[1]), 64'(N + 2));
      end
      if (nres == 3) begin
         for (int i = 0; i < 3; i++) begin
            model(bb_a[i], bb_b[i], bb_ci[i], es, eco, eerr);
            chk($sformatf("b2b_sum%0d", i), 64'(bb_s[i]), 64'(es));
         end
      end

      // Randomized transactions against the decimal model.
      for (int n = 0; n < 150; n++) begin
         logic [W-1:0] ra, rb;
         logic         rci;
         int           pos;
         for (int d = 0; d < N; d++) begin
            ra[4*d +: 4] = 4'($urandom_range(0, 9));
            rb[4*d +: 4] = 4'($urandom_range(0, 9));
         end
         if ($urandom_range(0, 7) == 0) begin
            pos = $urandom_range(0, 2 * N - 1);
            if (pos < N) ra[4*pos +: 4] = 4'($urandom_range(10, 15));
            else         rb[4*(pos-N) +: 4] = 4'($urandom_range(10, 15));
         end
         rci = 1'($urandom_range(0, 1));
         model(ra, rb, rci, es, eco, eerr);
         txn(ra, rb, rci, $urandom_range(0, 2), rs, rco, rerr, lat);
         chk($sformatf("rand%0d_sum a=%h b=%h ci=%0d", n, ra, rb, rci), 64'(rs), 64'(es));
         chk($sformatf("rand%0d_co", n), 64'(rco), 64'(eco));
         chk($sformatf("rand%0d_err", n), 64'(rerr), 64'(eerr));
         chk($sformatf("rand%0d_latency", n), 64'(lat), eerr ? 64'd0 : 64'(N));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
